// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async FIFO read-side pointer, address and status flag controller
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
  input  logic                  underflow_clr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  underflow
);
  localparam logic [ADDR_WIDTH:0] AE = (ADDR_WIDTH+1)'(AE_THRESH);
  logic [ADDR_WIDTH:0] rptr_bin, rbin_next, rgray_next, wbin, count_next;
  logic rd_accept;
  assign rd_accept = rd_en & ~empty;
  assign rbin_next = rptr_bin + {{ADDR_WIDTH{1'b0}}, rd_accept};
  assign rgray_next = rbin_next ^ (rbin_next >> 1);
  assign count_next = wbin - rbin_next;
  assign rd_addr = rptr_bin[ADDR_WIDTH-1:0];
  // Gray-to-binary of the synchronized write pointer, XOR-prefix from the MSB down
  always_comb begin
    wbin[ADDR_WIDTH] = wptr_gray_sync[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) wbin[i] = wbin[i+1] ^ wptr_gray_sync[i];
  end
  // Pointer advance and flag registration; flags see the post-accept pointer so the last read sets empty at once
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_bin     <= '0;
      rptr_gray    <= '0;
      rd_valid     <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      underflow    <= 1'b0;
    end else begin
      rptr_bin     <= rbin_next;
      rptr_gray    <= rgray_next;
      rd_valid     <= rd_accept;
      empty        <= rgray_next == wptr_gray_sync;
      almost_empty <= count_next <= AE;
      rd_count     <= count_next;
      underflow    <= (rd_en & empty) ? 1'b1 : underflow_clr ? 1'b0 : underflow;
    end
  end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed self-checking bench for the FIFO read controller
module tb_fifo_rd_ctrl;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst, rd_en, underflow_clr;
  logic [AW:0] wptr_gray_sync;
  logic [AW-1:0] rd_addr;
  logic [AW:0] rptr_gray, rd_count;
  logic rd_valid, empty, almost_empty, underflow;
  logic [AW:0] wb, rb;
  int total = 0;
  int bad = 0;

  fifo_rd_ctrl #(.ADDR_WIDTH(AW), .AE_THRESH(2)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wptr_gray_sync(wptr_gray_sync),
    .underflow_clr(underflow_clr), .rd_addr(rd_addr), .rptr_gray(rptr_gray),
    .rd_valid(rd_valid), .empty(empty), .almost_empty(almost_empty),
    .rd_count(rd_count), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW:0] g(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic e_empty, input logic e_ae,
                        input logic [AW:0] e_cnt, input logic e_valid,
                        input logic e_uf, input logic [AW:0] e_rptr);
    chk({tag, ".empty"}, 32'(empty), 32'(e_empty));
    chk({tag, ".ae"}, 32'(almost_empty), 32'(e_ae));
    chk({tag, ".count"}, 32'(rd_count), 32'(e_cnt));
    chk({tag, ".valid"}, 32'(rd_valid), 32'(e_valid));
    chk({tag, ".uf"}, 32'(underflow), 32'(e_uf));
    chk({tag, ".addr"}, 32'(rd_addr), 32'(e_rptr[AW-1:0]));
    chk({tag, ".gray"}, 32'(rptr_gray), 32'(g(e_rptr)));
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; underflow_clr = 1'b0; wptr_gray_sync = '0;
    for (int i = 0; i < 2; i++) begin
      rd_en = 1'($urandom_range(0, 1));
      step();
      chk_st("reset", 1, 1, 0, 0, 0, 0);
    end
    rst = 1'b0; rd_en = 1'b0;
    step();
    chk_st("idle", 1, 1, 0, 0, 0, 0);
    wptr_gray_sync = 5'b00001; step(); chk_st("fill1", 0, 1, 1, 0, 0, 0);
    wptr_gray_sync = 5'b00011; step(); chk_st("fill2", 0, 1, 2, 0, 0, 0);
    wptr_gray_sync = 5'b00010; step(); chk_st("fill3", 0, 0, 3, 0, 0, 0);
    rd_en = 1'b1;
    chk("drain.addr0", 32'(rd_addr), 0);
    step(); chk_st("drain1", 0, 1, 2, 1, 0, 1);
    step(); chk_st("drain2", 0, 1, 1, 1, 0, 2);
    step(); chk_st("drain3", 1, 1, 0, 1, 0, 3);
    step(); chk_st("drain4", 1, 1, 0, 0, 1, 3);
    rd_en = 1'b0; underflow_clr = 1'b1;
    step(); chk("uclr", 32'(underflow), 0);
    rd_en = 1'b1;
    step(); chk("uclr_set_prio", 32'(underflow), 1);
    chk("uclr_ptr_hold", 32'(rptr_gray), 32'(g(5'd3)));
    rd_en = 1'b0;
    step(); chk("uclr2", 32'(underflow), 0);
    underflow_clr = 1'b0;
    rst = 1'b1; wptr_gray_sync = '0;
    step();
    rst = 1'b0;
    wb = '0; rb = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) begin
        wb = wb + 1'b1;
        wptr_gray_sync = g(wb);
        step();
        chk("wr.count", 32'(rd_count), 32'(i + 1));
      end
      chk_st("full", 0, 0, 16, 0, 0, rb);
      rd_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
        chk("rd.addr", 32'(rd_addr), 32'(i));
        step();
        rb = rb + 1'b1;
        chk("rd.count", 32'(rd_count), 32'(15 - i));
        chk("rd.valid", 32'(rd_valid), 1);
      end
      rd_en = 1'b0;
      step();
      chk_st("drained", 1, 1, 0, 0, 0, rb);
    end
    chk("wrap.gray", 32'(rptr_gray), 0);
    for (int i = 0; i < 5; i++) begin
      wb = wb + 1'b1;
      wptr_gray_sync = g(wb);
      step();
    end
    chk_st("pre_rst", 0, 0, 5, 0, 0, 0);
    rd_en = 1'b1;
    step();
    chk_st("pre_rst_rd", 0, 0, 4, 1, 0, 1);
    rst = 1'b1;
    step();
    chk_st("mid_rst", 1, 1, 0, 0, 0, 0);
    rst = 1'b0; rd_en = 1'b0;
    step();
    chk_st("post_rst", 0, 0, 5, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
